m1_ebi_tx_serializer: RTL

Sits directly downstream of the M1-side EBI handshake stage. It accepts one completed message per M1→M2 channel (AR, AW, W, CR, CD) over a valid/push_ready handshake and buffers each channel in its own virtual-channel FIFO. It then arbitrates round-robin among non-empty channels and serializes the selected message, LSB first, into fixed-width flits on the M1→M2 link. A message is never interleaved with another on the link.

---
 rtl/ebi_pkg.sv | 35 +++
 rtl/m1_ebi_vc_fifo.sv | 69 ++++++
 rtl/m1_ebi_tx_serializer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ebi_pkg.sv
// ============================================================================
// Module  : ebi_pkg
// Brief   : Shared EBI constants: channel IDs, per-channel message lengths,
//           link flit width and the TX serializer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ebi_pkg;

  localparam int M1_M2_CHANNEL_NUM        = 5;
  localparam int MAX_M1_M2_MESSAGE_LENGTH = 160;
  localparam int EBI_FLIT_WIDTH           = 64;

  localparam int ID_AR = 0;
  localparam int ID_AW = 1;
  localparam int ID_W  = 2;
  localparam int ID_CR = 3;
  localparam int ID_CD = 4;

  // Valid message bits per channel, indexed by channel ID
  localparam int M1_M2_MSG_LEN [M1_M2_CHANNEL_NUM] = '{100, 100, 160, 40, 130};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ebi_tx_state_e;

  function automatic int ebi_nflit(input int ch, input int flit_w = EBI_FLIT_WIDTH);
    return (M1_M2_MSG_LEN[ch] + flit_w - 1) / flit_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/m1_ebi_vc_fifo.sv
// ============================================================================
// Module  : m1_ebi_vc_fifo
// Brief   : Synchronous per-channel FIFO with occupancy count, full and empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module m1_ebi_vc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (do_pop)  rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/m1_ebi_tx_serializer.sv
// ============================================================================
// Module  : m1_ebi_tx_serializer
// Brief   : Per-channel VC FIFOs, round-robin arbitration and LSB-first flit
//           serialization onto the M1->M2 link. Macro M1_EBI_TX_CREDIT_EN
//           adds per-channel credit flow control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module m1_ebi_tx_serializer
  import ebi_pkg::*;
#(
  parameter int CH_NUM     = M1_M2_CHANNEL_NUM,
  parameter int MSG_W      = MAX_M1_M2_MESSAGE_LENGTH,
  parameter int FLIT_W     = EBI_FLIT_WIDTH,
  parameter int VC_DEPTH   = 2,
  parameter int VC_CREDITS = 4
) (
  input  logic                          m1_clk_i,
  input  logic                          rst_ni,
  input  logic [CH_NUM-1:0]             m1_m2_channel_entry_valid_i,
  output logic [CH_NUM-1:0]             m1_m2_channel_push_ready_o,
  input  logic [CH_NUM-1:0][MSG_W-1:0]  m1_m2_channel_hs_entry_i,
  output logic                          link_valid_o,
  input  logic                          link_ready_i,
  output logic [FLIT_W-1:0]             link_data_o,
  output logic [$clog2(CH_NUM)-1:0]     link_vc_o,
  output logic                          link_last_o
`ifdef M1_EBI_TX_CREDIT_EN
  ,
  input  logic [CH_NUM-1:0]             credit_return_i
`endif
);

  localparam int VC_W      = $clog2(CH_NUM);
  localparam int MAX_NFLIT = (MSG_W + FLIT_W - 1) / FLIT_W;
  localparam int SH_W      = MAX_NFLIT * FLIT_W;
  localparam int BEAT_W    = $clog2(MAX_NFLIT + 1);

  if (VC_DEPTH < 1 || VC_CREDITS < 1) begin : g_bad_cfg
    $error("m1_ebi_tx_serializer: VC_DEPTH and VC_CREDITS must be >= 1");
  end

  ebi_tx_state_e             state_q, state_d;
  logic [SH_W-1:0]           shreg_q, shreg_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [VC_W-1:0]           vc_q, vc_d;
  logic [VC_W-1:0]           rr_ptr_q, rr_ptr_d;

  logic [CH_NUM-1:0]             fifo_full, fifo_empty, fifo_pop, credit_ok, eligible;
  logic [CH_NUM-1:0][MSG_W-1:0]  fifo_head;
  logic [VC_W-1:0]               rr_next, search_start, gnt_idx;
  logic [BEAT_W-1:0]             nflit_sel;
  logic                          gnt_found, accept, last_accept;

  // Clears the bits beyond a channel's valid length so the tail flit is zero-padded
  function automatic logic [MSG_W-1:0] msg_mask(input int ch);
    for (int b = 0; b < MSG_W; b++) msg_mask[b] = (b < M1_M2_MSG_LEN[ch]);
  endfunction

  for (genvar g = 0; g < CH_NUM; g++) begin : g_vc
    m1_ebi_vc_fifo #(
      .WIDTH (MSG_W),
      .DEPTH (VC_DEPTH)
    ) u_fifo (
      .clk_i   (m1_clk_i),
      .rst_ni  (rst_ni),
      .push_i  (m1_m2_channel_entry_valid_i[g] & m1_m2_channel_push_ready_o[g]),
      .pop_i   (fifo_pop[g]),
      .data_i  (m1_m2_channel_hs_entry_i[g]),
      .data_o  (fifo_head[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

  assign m1_m2_channel_push_ready_o = ~fifo_full & {CH_NUM{rst_ni}};
  assign eligible = ~fifo_empty & credit_ok;

  assign link_valid_o = (state_q == SEND);
  assign link_data_o  = shreg_q[FLIT_W-1:0];
  assign link_vc_o    = vc_q;
  assign link_last_o  = (state_q == SEND) && (beat_q == nflit_sel - BEAT_W'(1));
  assign accept       = link_valid_o & link_ready_i;
  assign last_accept  = accept & link_last_o;
  assign rr_next      = (vc_q == VC_W'(CH_NUM - 1)) ? '0 : vc_q + 1'b1;
  assign search_start = last_accept ? rr_next : rr_ptr_q;

  always_comb begin
    nflit_sel = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (vc_q == VC_W'(c)) nflit_sel = BEAT_W'(ebi_nflit(c, FLIT_W));
    end
  end

  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      idx = (int'(search_start) + i) % CH_NUM;
      if (!gnt_found && eligible[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = VC_W'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    beat_d   = beat_q;
    vc_d     = vc_q;
    rr_ptr_d = rr_ptr_q;
    fifo_pop = '0;
    if (accept) begin
      shreg_d = shreg_q >> FLIT_W;
      beat_d  = beat_q + 1'b1;
    end
    if (last_accept) begin
      rr_ptr_d = rr_next;
      state_d  = IDLE;
    end
    // A grant on the last-flit accept loads the next message with no idle cycle
    if ((state_q == IDLE || last_accept) && gnt_found) begin
      fifo_pop[gnt_idx] = 1'b1;
      shreg_d = SH_W'(fifo_head[gnt_idx] & msg_mask(int'(gnt_idx)));
      beat_d  = '0;
      vc_d    = gnt_idx;
      state_d = SEND;
    end
  end

  always_ff @(posedge m1_clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      beat_q   <= '0;
      vc_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      beat_q   <= beat_d;
      vc_q     <= vc_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef M1_EBI_TX_CREDIT_EN
  localparam int CR_W = $clog2(VC_CREDITS + 1);

  logic [CH_NUM-1:0][CR_W-1:0] credit_q, credit_d;

  always_comb begin
    credit_d = credit_q;
    for (int c = 0; c < CH_NUM; c++) begin
      if (fifo_pop[c] && !credit_return_i[c]) begin
        credit_d[c] = credit_q[c] - 1'b1;
      end else if (credit_return_i[c] && !fifo_pop[c] &&
                   credit_q[c] != CR_W'(VC_CREDITS)) begin
        credit_d[c] = credit_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge m1_clk_i) begin
    if (!rst_ni) begin
      credit_q <= {CH_NUM{CR_W'(VC_CREDITS)}};
    end else begin
      credit_q <= credit_d;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_credit
    assign credit_ok[g] = (credit_q[g] != '0);

    always @(posedge m1_clk_i) begin
      if (rst_ni) begin
        assert (!(credit_return_i[g] && !fifo_pop[g] && credit_q[g] == CR_W'(VC_CREDITS)))
          else $error("credit overflow on channel %0d", g);
      end
    end
  end
`else
  assign credit_ok = '1;
`endif

endmodule

`default_nettype wire
